// File: rtl/fire_controller.sv
// Battleship fire controller: accepts shots, scores them against a fixed ship map,
// and sweeps the grid to flag the cells of (and around) a freshly sunk ship.
module fire_controller #(
    parameter int MARK_ADJ = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fire_valid,
    output logic         fire_ready,
    input  logic [2:0]   fire_row,
    input  logic [2:0]   fire_col,
    input  logic [191:0] ship_map,
    output logic [63:0]  shot_vec,
    output logic [63:0]  sunk_vec,
    output logic         result_valid,
    output logic [1:0]   result_code,
    output logic [2:0]   ships_left,
    output logic         game_over
);

    typedef enum logic [2:0] {IDLE, EVAL, SWEEP, REPORT, OVER} state_t;

    localparam logic [1:0] CODE_MISS   = 2'd0;
    localparam logic [1:0] CODE_HIT    = 2'd1;
    localparam logic [1:0] CODE_SUNK   = 2'd2;
    localparam logic [1:0] CODE_REPEAT = 2'd3;

    state_t      state;
    logic [5:0]  idx;
    logic [5:0]  sweep_idx;
    logic [63:0] bitmap;
    logic [2:0]  hit_cnt [5];
    logic [2:0]  sunk_id;
    logic [2:0]  ships_left_q;
    logic [1:0]  code_q;

    logic [2:0]  cur_id;
    logic        cur_is_ship;
    logic [2:0]  hit_next;
    logic        sweep_hit;

    function automatic logic [2:0] ship_len(input logic [2:0] id);
        case (id)
            3'd1:    ship_len = 3'd5;
            3'd2:    ship_len = 3'd4;
            3'd3:    ship_len = 3'd3;
            3'd4:    ship_len = 3'd3;
            3'd5:    ship_len = 3'd2;
            default: ship_len = 3'd0;
        endcase
    endfunction

    always_comb begin
        cur_id      = ship_map[idx*3 +: 3];
        cur_is_ship = (cur_id >= 3'd1) && (cur_id <= 3'd5);
        hit_next    = hit_cnt[cur_id - 3'd1] + 3'd1;
    end

    // Neighbours outside the grid are skipped, so column 7 never sees column 0.
    always_comb begin
        int sr, sc, r, c;
        sweep_hit = 1'b0;
        sr = int'(sweep_idx[5:3]);
        sc = int'(sweep_idx[2:0]);
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = sr + dr;
                c = sc + dc;
                if (r >= 0 && r < 8 && c >= 0 && c < 8 &&
                    (MARK_ADJ != 0 || (dr == 0 && dc == 0))) begin
                    if (ship_map[(r*8 + c)*3 +: 3] == sunk_id)
                        sweep_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            sweep_idx    <= '0;
            bitmap       <= '0;
            sunk_id      <= '0;
            ships_left_q <= 3'd5;
            code_q       <= CODE_MISS;
            for (int i = 0; i < 5; i++)
                hit_cnt[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire_valid) begin
                        idx   <= {fire_row, fire_col};
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (bitmap[idx]) begin
                        code_q <= CODE_REPEAT;
                        state  <= REPORT;
                    end else begin
                        bitmap[idx] <= 1'b1;
                        if (cur_is_ship) begin
                            hit_cnt[cur_id - 3'd1] <= hit_next;
                            if (hit_next == ship_len(cur_id)) begin
                                code_q    <= CODE_SUNK;
                                sunk_id   <= cur_id;
                                sweep_idx <= '0;
                                state     <= SWEEP;
                            end else begin
                                code_q <= CODE_HIT;
                                state  <= REPORT;
                            end
                        end else begin
                            code_q <= CODE_MISS;
                            state  <= REPORT;
                        end
                    end
                end
                SWEEP: begin
                    if (sweep_idx == 6'd63) begin
                        ships_left_q <= ships_left_q - 3'd1;
                        state        <= REPORT;
                    end else begin
                        sweep_idx <= sweep_idx + 6'd1;
                    end
                end
                REPORT: state <= (ships_left_q == 3'd0) ? OVER : IDLE;
                OVER:   state <= OVER;
                default: state <= IDLE;
            endcase
        end
    end

    assign fire_ready   = (state == IDLE);
    assign shot_vec     = (state == EVAL && !bitmap[idx]) ? (64'd1 << idx) : 64'd0;
    assign sunk_vec     = (state == SWEEP && sweep_hit) ? (64'd1 << sweep_idx) : 64'd0;
    assign result_valid = (state == REPORT);
    assign result_code  = code_q;
    assign ships_left   = ships_left_q;
    assign game_over    = (state == OVER);

endmodule

// File: tb/tb_fire_controller.sv
// Directed bench for fire_controller; a second instance with MARK_ADJ=0 shares all stimulus.
module tb_fire_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic         fire_valid;
    logic [2:0]   fire_row;
    logic [2:0]   fire_col;
    logic [191:0] ship_map;

    logic         fire_ready,   fire_ready_0;
    logic [63:0]  shot_vec,     shot_vec_0;
    logic [63:0]  sunk_vec,     sunk_vec_0;
    logic         result_valid, result_valid_0;
    logic [1:0]   result_code,  result_code_0;
    logic [2:0]   ships_left,   ships_left_0;
    logic         game_over,    game_over_0;

    int n_cmp = 0;
    int n_bad = 0;

    // shoot() results
    logic [1:0]   r_code;
    int           r_lat;
    int           r_shot_cycles;
    logic [63:0]  r_shot_or;
    logic [63:0]  r_sunk_or;
    logic [63:0]  r_sunk_or_0;

    always #5 clk = ~clk;

    fire_controller #(.MARK_ADJ(1)) dut (
        .clk(clk), .reset(reset), .fire_valid(fire_valid), .fire_ready(fire_ready),
        .fire_row(fire_row), .fire_col(fire_col), .ship_map(ship_map),
        .shot_vec(shot_vec), .sunk_vec(sunk_vec), .result_valid(result_valid),
        .result_code(result_code), .ships_left(ships_left), .game_over(game_over)
    );

    fire_controller #(.MARK_ADJ(0)) dut0 (
        .clk(clk), .reset(reset), .fire_valid(fire_valid), .fire_ready(fire_ready_0),
        .fire_row(fire_row), .fire_col(fire_col), .ship_map(ship_map),
        .shot_vec(shot_vec_0), .sunk_vec(sunk_vec_0), .result_valid(result_valid_0),
        .result_code(result_code_0), .ships_left(ships_left_0), .game_over(game_over_0)
    );

    task automatic set_cell(input int r, input int c, input logic [2:0] id);
        ship_map[(r*8 + c)*3 +: 3] = id;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        fire_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Accept one shot, then watch until result_valid; r_lat counts edges from the accept edge.
    task automatic shoot(input int r, input int c);
        int waited;
        r_code = 2'd0; r_lat = -1; r_shot_cycles = 0;
        r_shot_or = '0; r_sunk_or = '0; r_sunk_or_0 = '0;
        waited = 0;
        @(negedge clk);
        while (!fire_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!fire_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL shoot_ready (%0d,%0d): fire_ready=%b required 1", r, c, fire_ready);
            return;
        end
        fire_valid = 1'b1;
        fire_row   = 3'(r);
        fire_col   = 3'(c);
        @(posedge clk);
        #1;
        fire_valid = 1'b0;
        fire_row   = ~3'(r);
        fire_col   = ~3'(c);
        for (int j = 0; j < 80; j++) begin
            r_shot_or   = r_shot_or | shot_vec;
            r_sunk_or   = r_sunk_or | sunk_vec;
            r_sunk_or_0 = r_sunk_or_0 | sunk_vec_0;
            if (shot_vec != 64'd0) r_shot_cycles++;
            if (result_valid) begin
                r_lat  = j + 1;
                r_code = result_code;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (r_lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL shoot_timeout (%0d,%0d): no result_valid within 80 cycles", r, c);
        end
    endtask

    task automatic test_reset();
        ship_map = '0;
        do_reset();
        n_cmp++; if (fire_ready !== 1'b1)      begin n_bad++; $display("FAIL reset_ready: got %b want 1", fire_ready); end
        n_cmp++; if (ships_left !== 3'd5)      begin n_bad++; $display("FAIL reset_ships_left: got %0d want 5", ships_left); end
        n_cmp++; if (game_over !== 1'b0)       begin n_bad++; $display("FAIL reset_game_over: got %b want 0", game_over); end
        n_cmp++; if (result_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
        n_cmp++; if (result_code !== 2'd0)     begin n_bad++; $display("FAIL reset_result_code: got %0d want 0", result_code); end
        n_cmp++; if (shot_vec !== 64'd0)       begin n_bad++; $display("FAIL reset_shot_vec: got %h want 0", shot_vec); end
        n_cmp++; if (sunk_vec !== 64'd0)       begin n_bad++; $display("FAIL reset_sunk_vec: got %h want 0", sunk_vec); end
    endtask

    task automatic test_miss();
        shoot(2, 3);
        n_cmp++; if (r_shot_or !== (64'd1 << 19)) begin n_bad++; $display("FAIL miss_shot_vec: got %h want %h", r_shot_or, 64'd1 << 19); end
        n_cmp++; if (r_shot_cycles !== 1)         begin n_bad++; $display("FAIL miss_shot_cycles: got %0d want 1", r_shot_cycles); end
        n_cmp++; if (r_lat !== 2)                 begin n_bad++; $display("FAIL miss_latency: got %0d want 2", r_lat); end
        n_cmp++; if (r_code !== 2'd0)             begin n_bad++; $display("FAIL miss_code: got %0d want 0", r_code); end
        n_cmp++; if (ships_left !== 3'd5)         begin n_bad++; $display("FAIL miss_ships_left: got %0d want 5", ships_left); end
    endtask

    task automatic test_repeat();
        shoot(2, 3);
        n_cmp++; if (r_shot_or !== 64'd0) begin n_bad++; $display("FAIL repeat_shot_vec: got %h want 0", r_shot_or); end
        n_cmp++; if (r_code !== 2'd3)     begin n_bad++; $display("FAIL repeat_code: got %0d want 3", r_code); end
        n_cmp++; if (r_lat !== 2)         begin n_bad++; $display("FAIL repeat_latency: got %0d want 2", r_lat); end
        n_cmp++; if (ships_left !== 3'd5) begin n_bad++; $display("FAIL repeat_ships_left: got %0d want 5", ships_left); end
    endtask

    task automatic test_sink_adj();
        logic [63:0] exp_adj, exp_own;
        exp_adj = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 2) | (64'd1 << 8) | (64'd1 << 9) | (64'd1 << 10);
        exp_own = (64'd1 << 0) | (64'd1 << 1);
        ship_map = '0;
        set_cell(0, 0, 3'd5);
        set_cell(0, 1, 3'd5);
        do_reset();
        shoot(0, 0);
        n_cmp++; if (r_code !== 2'd1) begin n_bad++; $display("FAIL sink_first_code: got %0d want 1", r_code); end
        shoot(0, 1);
        n_cmp++; if (r_code !== 2'd2)          begin n_bad++; $display("FAIL sink_code: got %0d want 2", r_code); end
        n_cmp++; if (r_lat !== 66)             begin n_bad++; $display("FAIL sink_latency: got %0d want 66", r_lat); end
        n_cmp++; if (r_sunk_or !== exp_adj)    begin n_bad++; $display("FAIL sink_adj_vec: got %h want %h", r_sunk_or, exp_adj); end
        n_cmp++; if (r_sunk_or_0 !== exp_own)  begin n_bad++; $display("FAIL sink_noadj_vec: got %h want %h", r_sunk_or_0, exp_own); end
        n_cmp++; if (ships_left !== 3'd4)      begin n_bad++; $display("FAIL sink_ships_left: got %0d want 4", ships_left); end
    endtask

    task automatic test_edge_wrap();
        logic [63:0] exp_adj, exp_own;
        exp_adj = (64'd1 << 6) | (64'd1 << 7) | (64'd1 << 14) | (64'd1 << 15) | (64'd1 << 22) | (64'd1 << 23);
        exp_own = (64'd1 << 7) | (64'd1 << 15);
        ship_map = '0;
        set_cell(0, 7, 3'd5);
        set_cell(1, 7, 3'd5);
        do_reset();
        shoot(0, 7);
        shoot(1, 7);
        n_cmp++; if (r_code !== 2'd2)         begin n_bad++; $display("FAIL wrap_code: got %0d want 2", r_code); end
        n_cmp++; if (r_sunk_or !== exp_adj)   begin n_bad++; $display("FAIL wrap_adj_vec: got %h want %h", r_sunk_or, exp_adj); end
        n_cmp++; if (r_sunk_or_0 !== exp_own) begin n_bad++; $display("FAIL wrap_noadj_vec: got %h want %h", r_sunk_or_0, exp_own); end
    endtask

    task automatic test_game_over();
        int rows [5] = '{0, 2, 4, 6, 7};
        int col0 [5] = '{0, 0, 0, 0, 6};
        int lens [5] = '{5, 4, 3, 3, 2};
        int seen_ready;
        ship_map = '0;
        for (int s = 0; s < 5; s++)
            for (int k = 0; k < lens[s]; k++)
                set_cell(rows[s], col0[s] + k, 3'(s + 1));
        do_reset();
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < lens[s]; k++) begin
                shoot(rows[s], col0[s] + k);
                if (k == lens[s] - 1) begin
                    n_cmp++; if (r_code !== 2'd2) begin n_bad++; $display("FAIL over_sunk_code ship%0d: got %0d want 2", s + 1, r_code); end
                    n_cmp++; if (ships_left !== 3'(4 - s)) begin n_bad++; $display("FAIL over_ships_left ship%0d: got %0d want %0d", s + 1, ships_left, 4 - s); end
                end else begin
                    n_cmp++; if (r_code !== 2'd1) begin n_bad++; $display("FAIL over_hit_code ship%0d cell%0d: got %0d want 1", s + 1, k, r_code); end
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (game_over !== 1'b1)  begin n_bad++; $display("FAIL over_game_over: got %b want 1", game_over); end
        n_cmp++; if (ships_left !== 3'd0) begin n_bad++; $display("FAIL over_ships_zero: got %0d want 0", ships_left); end
        fire_valid = 1'b1;
        fire_row   = 3'd3;
        fire_col   = 3'd3;
        seen_ready = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fire_ready !== 1'b0 || result_valid !== 1'b0 || game_over !== 1'b1) seen_ready++;
        end
        fire_valid = 1'b0;
        n_cmp++; if (seen_ready !== 0) begin n_bad++; $display("FAIL over_hold: got %0d bad cycles want 0", seen_ready); end
    endtask

    task automatic test_reset_mid_sweep();
        int pulses;
        ship_map = '0;
        set_cell(0, 0, 3'd5);
        set_cell(0, 1, 3'd5);
        do_reset();
        shoot(0, 0);
        @(negedge clk);
        while (!fire_ready) @(negedge clk);
        fire_valid = 1'b1;
        fire_row   = 3'd0;
        fire_col   = 3'd1;
        @(posedge clk);
        #1 fire_valid = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        // sweep index is now 30
        n_cmp++; if (dut.sweep_idx !== 6'd30) begin n_bad++; $display("FAIL mid_sweep_index: got %0d want 30", dut.sweep_idx); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++; if (fire_ready !== 1'b1)   begin n_bad++; $display("FAIL mid_reset_ready: got %b want 1", fire_ready); end
        n_cmp++; if (sunk_vec !== 64'd0)    begin n_bad++; $display("FAIL mid_reset_sunk_vec: got %h want 0", sunk_vec); end
        n_cmp++; if (ships_left !== 3'd5)   begin n_bad++; $display("FAIL mid_reset_ships_left: got %0d want 5", ships_left); end
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            if (result_valid || sunk_vec != 64'd0) pulses++;
            @(posedge clk);
            #1;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL mid_reset_no_result: got %0d pulses want 0", pulses); end
    endtask

    initial begin
        reset      = 1'b1;
        fire_valid = 1'b0;
        fire_row   = 3'd0;
        fire_col   = 3'd0;
        ship_map   = '0;
        test_reset();
        test_miss();
        test_repeat();
        test_sink_adj();
        test_edge_wrap();
        test_game_over();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
